// File: rtl/base_address_wr.sv
// Streams NUM_WORDS words into a BRAM mailbox from START_ADDR, then posts
// FLAG_VALUE at FLAG_ADDR and holds Transfer_Done until the next start.
module base_address_wr #(
    parameter logic [31:0] START_ADDR = 32'h4580_0000,
    parameter int unsigned NUM_WORDS  = 4,
    parameter logic [31:0] FLAG_ADDR  = 32'h4580_0FFC,
    parameter logic [31:0] FLAG_VALUE = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        ram_clk,
    output logic        ram_rst,
    output logic [31:0] ram_addr,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_wd_data,
    input  logic [31:0] ram_rd_data,
    output logic        Transfer_Done
);

    localparam int unsigned IDX_W    = 8;
    localparam int unsigned ADDR_W   = 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        FLAG  = 3'd2,
        FIN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               en_q, en_d;
    logic [3:0]         we_q, we_d;
    logic               done_q, done_d;
    logic               beat_c;
    logic               unused_rd_c;

    assign ram_clk     = clk;
    assign ram_rst     = 1'b0;
    assign unused_rd_c = ^ram_rd_data;

    assign wr_ready = (state_q == WRITE);
    assign beat_c   = wr_ready && wr_valid;

    // State and registered BRAM bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            en_q    <= 1'b0;
            we_q    <= 4'h0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            en_q    <= en_d;
            we_q    <= we_d;
            done_q  <= done_d;
        end
    end

    // Next state; the bus strobes default low so idle cycles never write.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        en_d    = 1'b0;
        we_d    = 4'h0;
        done_d  = done_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (beat_c) begin
                    addr_d  = START_ADDR + {22'b0, idx_q, 2'b00};
                    wdata_d = wr_data;
                    en_d    = 1'b1;
                    we_d    = 4'hF;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = FLAG;
                    end
                end
            end
            FLAG: begin
                addr_d  = FLAG_ADDR;
                wdata_d = FLAG_VALUE;
                en_d    = 1'b1;
                we_d    = 4'hF;
                state_d = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    done_d  = 1'b0;
                    idx_d   = '0;
                    state_d = WRITE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ram_addr      = addr_q;
    assign ram_wd_data   = wdata_q;
    assign ram_en        = en_q;
    assign ram_we        = we_q;
    assign Transfer_Done = done_q;

endmodule
